// File: rtl/sprite_layer_mux_if.sv
// Bundle between the per-object drawers and the layer mux: object requests,
// colours, priority-table writes in; merged pixel and collision flags out.
interface sprite_layer_mux_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned RGB_W  = 8
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            chRequest;
    logic [NUM_CH-1:0][RGB_W-1:0] chRGB;
    logic [NUM_CH-1:0]            chEnable;
    logic                         startOfFrame;
    logic                         prioWrEn;
    logic [CH_W-1:0]              prioWrSlot;
    logic [CH_W-1:0]              prioWrCh;

    logic                         drawingRequest;
    logic [RGB_W-1:0]             rgbOut;
    logic [CH_W-1:0]              topCh;
    logic [NUM_CH-1:0]            collisionLive;
    logic [NUM_CH-1:0]            collisionFrame;
    logic                         collisionPulse;

    modport master (
        output chRequest, chRGB, chEnable, startOfFrame,
               prioWrEn, prioWrSlot, prioWrCh,
        input  drawingRequest, rgbOut, topCh,
               collisionLive, collisionFrame, collisionPulse
    );

    modport slave (
        input  chRequest, chRGB, chEnable, startOfFrame,
               prioWrEn, prioWrSlot, prioWrCh,
        output drawingRequest, rgbOut, topCh,
               collisionLive, collisionFrame, collisionPulse
    );
endinterface

// File: rtl/sprite_layer_mux.sv
// Programmable-priority sprite layer multiplexer with frame-synchronous
// priority table and per-frame collision accumulation. All outputs registered.
module sprite_layer_mux #(
    parameter int unsigned      NUM_CH = 8,
    parameter int unsigned      RGB_W  = 8,
    parameter logic [RGB_W-1:0] BG_RGB = RGB_W'(8'hFF)
) (
    input  logic               clk,
    input  logic               reset,
    sprite_layer_mux_if.slave  bus
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(NUM_CH + 1);

    typedef logic [NUM_CH-1:0][CH_W-1:0] prio_table_t;

    prio_table_t       shadow_q;
    prio_table_t       active_q;
    prio_table_t       shadow_nxt;

    logic [NUM_CH-1:0] eff;
    logic              win_found;
    logic [CH_W-1:0]   win_ch;
    logic [CNT_W-1:0]  req_cnt;
    logic              overlap;
    logic [NUM_CH-1:0] overlap_bits;
    logic [NUM_CH-1:0] live_nxt;

    logic              draw_q;
    logic [RGB_W-1:0]  rgb_q;
    logic [CH_W-1:0]   top_q;
    logic [NUM_CH-1:0] live_q;
    logic [NUM_CH-1:0] frame_q;
    logic              pulse_q;

    always_comb begin
        eff = bus.chRequest & bus.chEnable;
    end

    // First slot whose channel has an effective request wins.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        for (int unsigned s = 0; s < NUM_CH; s++) begin
            if (!win_found && (32'(active_q[s]) < NUM_CH) && eff[active_q[s]]) begin
                win_found = 1'b1;
                win_ch    = active_q[s];
            end
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            req_cnt = req_cnt + CNT_W'(eff[i]);
        end
        overlap      = (req_cnt >= CNT_W'(2));
        overlap_bits = overlap ? eff : '0;
    end

    // The shadow write is folded in before the frame-start copy so a write on
    // the startOfFrame cycle lands in the active table too.
    always_comb begin
        shadow_nxt = shadow_q;
        if (bus.prioWrEn && (32'(bus.prioWrSlot) < NUM_CH)) begin
            shadow_nxt[bus.prioWrSlot] = bus.prioWrCh;
        end
    end

    always_comb begin
        live_nxt = bus.startOfFrame ? overlap_bits : (live_q | overlap_bits);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_CH; s++) begin
                shadow_q[s] <= CH_W'(s);
                active_q[s] <= CH_W'(s);
            end
            draw_q  <= 1'b0;
            rgb_q   <= BG_RGB;
            top_q   <= '0;
            live_q  <= '0;
            frame_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            shadow_q <= shadow_nxt;
            if (bus.startOfFrame) begin
                active_q <= shadow_nxt;
                frame_q  <= live_q;
            end
            draw_q  <= win_found;
            rgb_q   <= win_found ? bus.chRGB[win_ch] : BG_RGB;
            top_q   <= win_found ? win_ch : '0;
            live_q  <= live_nxt;
            pulse_q <= overlap;
        end
    end

    assign bus.drawingRequest = draw_q;
    assign bus.rgbOut         = rgb_q;
    assign bus.topCh          = top_q;
    assign bus.collisionLive  = live_q;
    assign bus.collisionFrame = frame_q;
    assign bus.collisionPulse = pulse_q;

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Directed bench for sprite_layer_mux with NUM_CH=8, RGB_W=8.
module tb_sprite_layer_mux;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    sprite_layer_mux_if #(.NUM_CH(8), .RGB_W(8)) bus ();

    sprite_layer_mux #(.NUM_CH(8), .RGB_W(8), .BG_RGB(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.chRequest    = 8'h00;
        bus.chEnable     = 8'hFF;
        bus.startOfFrame = 1'b0;
        bus.prioWrEn     = 1'b0;
        bus.prioWrSlot   = 3'd0;
        bus.prioWrCh     = 3'd0;
        bus.chRGB[0] = 8'h03; bus.chRGB[1] = 8'h1C;
        bus.chRGB[2] = 8'hE0; bus.chRGB[3] = 8'h25;
        bus.chRGB[4] = 8'h4A; bus.chRGB[5] = 8'h6D;
        bus.chRGB[6] = 8'h92; bus.chRGB[7] = 8'hB6;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.drawingRequest !== 1'b0) begin n_fail++; $display("FAIL reset_draw got %b want 0", bus.drawingRequest); end
        n_cmp++; if (bus.rgbOut !== 8'hFF) begin n_fail++; $display("FAIL reset_rgb got %h want ff", bus.rgbOut); end
        n_cmp++; if (bus.topCh !== 3'd0) begin n_fail++; $display("FAIL reset_top got %0d want 0", bus.topCh); end
        n_cmp++; if (bus.collisionPulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", bus.collisionPulse); end
        n_cmp++; if (bus.collisionLive !== 8'h00 || bus.collisionFrame !== 8'h00) begin n_fail++; $display("FAIL reset_coll got live=%b frame=%b want 0/0", bus.collisionLive, bus.collisionFrame); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        bus.chRequest = 8'b0000_0110;
        tick();
        n_cmp++; if (bus.drawingRequest !== 1'b1) begin n_fail++; $display("FAIL ident_draw got %b want 1", bus.drawingRequest); end
        n_cmp++; if (bus.rgbOut !== 8'h1C) begin n_fail++; $display("FAIL ident_rgb got %h want 1c", bus.rgbOut); end
        n_cmp++; if (bus.topCh !== 3'd1) begin n_fail++; $display("FAIL ident_top got %0d want 1", bus.topCh); end
        n_cmp++; if (bus.collisionPulse !== 1'b1) begin n_fail++; $display("FAIL ident_pulse got %b want 1", bus.collisionPulse); end
        n_cmp++; if (bus.collisionLive !== 8'b0000_0110) begin n_fail++; $display("FAIL ident_live got %b want 00000110", bus.collisionLive); end
    endtask

    task automatic test_no_request();
        bus.chRequest = 8'h00;
        tick();
        n_cmp++; if (bus.rgbOut !== 8'hFF) begin n_fail++; $display("FAIL noreq_rgb got %h want ff", bus.rgbOut); end
        n_cmp++; if (bus.drawingRequest !== 1'b0 || bus.topCh !== 3'd0) begin n_fail++; $display("FAIL noreq_draw_top got %b/%0d want 0/0", bus.drawingRequest, bus.topCh); end
        n_cmp++; if (bus.collisionPulse !== 1'b0 || bus.collisionLive !== 8'b0000_0110) begin n_fail++; $display("FAIL noreq_sticky got pulse=%b live=%b want 0/00000110", bus.collisionPulse, bus.collisionLive); end
    endtask

    task automatic test_enable_mask();
        bus.chRequest = 8'b0000_0110;
        bus.chEnable  = 8'hFD;
        tick();
        n_cmp++; if (bus.rgbOut !== 8'hE0 || bus.topCh !== 3'd2) begin n_fail++; $display("FAIL mask_win got rgb=%h top=%0d want e0/2", bus.rgbOut, bus.topCh); end
        n_cmp++; if (bus.collisionPulse !== 1'b0) begin n_fail++; $display("FAIL mask_pulse got %b want 0", bus.collisionPulse); end
        bus.chEnable = 8'hFF;
    endtask

    task automatic test_prio_write();
        // Mid-frame write: slot0 <- ch2, no visible effect until after startOfFrame.
        bus.chRequest  = 8'b0000_0110;
        bus.prioWrEn   = 1'b1;
        bus.prioWrSlot = 3'd0;
        bus.prioWrCh   = 3'd2;
        tick();
        bus.prioWrEn = 1'b0;
        n_cmp++; if (bus.topCh !== 3'd1) begin n_fail++; $display("FAIL wr_hold0 got top=%0d want 1", bus.topCh); end
        tick();
        n_cmp++; if (bus.topCh !== 3'd1) begin n_fail++; $display("FAIL wr_hold1 got top=%0d want 1", bus.topCh); end
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.topCh !== 3'd1) begin n_fail++; $display("FAIL wr_sof_edge got top=%0d want 1", bus.topCh); end
        n_cmp++; if (bus.collisionFrame !== 8'b0000_0110 || bus.collisionLive !== 8'b0000_0110) begin n_fail++; $display("FAIL wr_sof_coll got frame=%b live=%b want 00000110/00000110", bus.collisionFrame, bus.collisionLive); end
        tick();
        n_cmp++; if (bus.topCh !== 3'd2 || bus.rgbOut !== 8'hE0) begin n_fail++; $display("FAIL wr_after got top=%0d rgb=%h want 2/e0", bus.topCh, bus.rgbOut); end
    endtask

    task automatic test_write_with_sof();
        // Write slot0 <- ch1 on the startOfFrame cycle itself.
        bus.chRequest    = 8'b0000_0110;
        bus.prioWrEn     = 1'b1;
        bus.prioWrSlot   = 3'd0;
        bus.prioWrCh     = 3'd1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.prioWrEn     = 1'b0;
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.topCh !== 3'd2) begin n_fail++; $display("FAIL wsof_edge got top=%0d want 2", bus.topCh); end
        tick();
        n_cmp++; if (bus.topCh !== 3'd1 || bus.rgbOut !== 8'h1C) begin n_fail++; $display("FAIL wsof_after got top=%0d rgb=%h want 1/1c", bus.topCh, bus.rgbOut); end
        // Table is now {1,1,2,3,4,5,6,7}: ch0 sits in no slot.
        bus.chRequest = 8'b0000_0001;
        tick();
        n_cmp++; if (bus.drawingRequest !== 1'b0 || bus.rgbOut !== 8'hFF || bus.topCh !== 3'd0) begin n_fail++; $display("FAIL orphan got draw=%b rgb=%h top=%0d want 0/ff/0", bus.drawingRequest, bus.rgbOut, bus.topCh); end
        bus.chRequest = 8'b0000_1001;
        tick();
        n_cmp++; if (bus.topCh !== 3'd3 || bus.collisionPulse !== 1'b1) begin n_fail++; $display("FAIL orphan_coll got top=%0d pulse=%b want 3/1", bus.topCh, bus.collisionPulse); end
    endtask

    task automatic test_collision_frames();
        bus.chRequest    = 8'h00;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.collisionLive !== 8'h00) begin n_fail++; $display("FAIL frameA_start got live=%b want 0", bus.collisionLive); end
        bus.chRequest = 8'b0010_1000;
        tick();
        n_cmp++; if (bus.collisionLive !== 8'b0010_1000 || bus.topCh !== 3'd3 || bus.rgbOut !== 8'h25) begin n_fail++; $display("FAIL frameA_ovl got live=%b top=%0d rgb=%h want 00101000/3/25", bus.collisionLive, bus.topCh, bus.rgbOut); end
        bus.chRequest = 8'b0000_1000;
        repeat (2) tick();
        bus.chRequest    = 8'h00;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.collisionFrame !== 8'b0010_1000 || bus.collisionLive !== 8'h00) begin n_fail++; $display("FAIL frameB_start got frame=%b live=%b want 00101000/0", bus.collisionFrame, bus.collisionLive); end
        bus.chRequest = 8'b0010_0000;
        repeat (3) tick();
        bus.chRequest    = 8'h00;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.collisionFrame !== 8'h00 || bus.collisionLive !== 8'h00) begin n_fail++; $display("FAIL frameC_start got frame=%b live=%b want 0/0", bus.collisionFrame, bus.collisionLive); end
    endtask

    task automatic test_sof_overlap();
        bus.chRequest = 8'b0001_0100;
        tick();
        n_cmp++; if (bus.collisionLive !== 8'b0001_0100) begin n_fail++; $display("FAIL frameC_live got %b want 00010100", bus.collisionLive); end
        bus.chRequest    = 8'b1000_0001;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        n_cmp++; if (bus.collisionLive !== 8'b1000_0001 || bus.collisionFrame !== 8'b0001_0100) begin n_fail++; $display("FAIL sof_ovl got live=%b frame=%b want 10000001/00010100", bus.collisionLive, bus.collisionFrame); end
        n_cmp++; if (bus.collisionPulse !== 1'b1 || bus.topCh !== 3'd7 || bus.rgbOut !== 8'hB6) begin n_fail++; $display("FAIL sof_ovl_win got pulse=%b top=%0d rgb=%h want 1/7/b6", bus.collisionPulse, bus.topCh, bus.rgbOut); end
    endtask

    task automatic test_reset_midframe();
        bus.chRequest = 8'b0000_0011;
        tick();
        reset = 1'b1;
        #2;
        n_cmp++; if (bus.drawingRequest !== 1'b0 || bus.rgbOut !== 8'hFF || bus.topCh !== 3'd0) begin n_fail++; $display("FAIL midrst_pix got draw=%b rgb=%h top=%0d want 0/ff/0", bus.drawingRequest, bus.rgbOut, bus.topCh); end
        n_cmp++; if (bus.collisionPulse !== 1'b0 || bus.collisionLive !== 8'h00 || bus.collisionFrame !== 8'h00) begin n_fail++; $display("FAIL midrst_coll got pulse=%b live=%b frame=%b want 0/0/0", bus.collisionPulse, bus.collisionLive, bus.collisionFrame); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_cmp++; if (bus.topCh !== 3'd0 || bus.rgbOut !== 8'h03 || bus.drawingRequest !== 1'b1) begin n_fail++; $display("FAIL postrst_win got top=%0d rgb=%h draw=%b want 0/03/1", bus.topCh, bus.rgbOut, bus.drawingRequest); end
        n_cmp++; if (bus.collisionPulse !== 1'b1 || bus.collisionLive !== 8'b0000_0011) begin n_fail++; $display("FAIL postrst_coll got pulse=%b live=%b want 1/00000011", bus.collisionPulse, bus.collisionLive); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_identity();
        test_no_request();
        test_enable_mask();
        test_prio_write();
        test_write_with_sof();
        test_collision_frames();
        test_sof_overlap();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_layer_mux.md
# sprite_layer_mux

Parametrised, programmable-priority layer multiplexer for the VGA object pipeline. It merges NUM_CH per-object drawing requests and colours into one registered pixel, in an order set by a frame-synchronous priority table. It also accumulates per-frame overlap (collision) flags per channel. It sits between the per-object drawers and the top-level display mux, replacing fixed-order 4-way group muxes.

## Interface
Parameters:
- NUM_CH, 8, number of object channels (≥2); CH_W = $clog2(NUM_CH)
- RGB_W, 8, colour width per channel
- BG_RGB, 8'hFF, colour driven when no channel wins

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- reset  in  1  async active-high reset
- chRequest  in  NUM_CH  per-channel drawing request
- chRGB  in  NUM_CH×RGB_W  per-channel colour, packed [NUM_CH-1:0][RGB_W-1:0]
- chEnable  in  NUM_CH  per-channel mask; 0 = channel ignored for drawing and collision
- startOfFrame  in  1  one-cycle pulse on first pixel of a frame
- prioWrEn  in  1  priority table write strobe
- prioWrSlot  in  CH_W  slot written (0 = highest priority)
- prioWrCh  in  CH_W  channel placed in that slot
- drawingRequest  out  1  any enabled channel requested (registered)
- rgbOut  out  RGB_W  winning colour or BG_RGB (registered)
- topCh  out  CH_W  winning channel index, 0 when none (registered)
- collisionLive  out  NUM_CH  channels involved in an overlap so far this frame
- collisionFrame  out  NUM_CH  collisionLive snapshot from the completed previous frame
- collisionPulse  out  1  one-cycle pulse: current pixel had ≥2 enabled requests

## Operation
- Effective request: eff[i] = chRequest[i] & chEnable[i].
- Priority tables: shadow and active, NUM_CH entries of CH_W bits each. Reset value of both: slot s holds channel s (channel 0 highest).
- Write: prioWrEn updates shadow[prioWrSlot] <= prioWrCh. On startOfFrame, active <= shadow. Write and startOfFrame in the same cycle: the written value is included in the copy to active.
- The table is not checked for duplicates. A channel present in no slot never wins, but still counts toward collisions.
- Winner: scan slots 0..NUM_CH-1; the first slot s with eff[active[s]]=1 wins. Outputs are drawingRequest=1, rgbOut=chRGB[active[s]], topCh=active[s].
- No winner: drawingRequest=0, rgbOut=BG_RGB, topCh=0.
- Overlap: popcount(eff) ≥ 2 sets collisionPulse. It also ORs eff into collisionLive (sticky).
- Frame boundary: on startOfFrame, collisionFrame <= collisionLive (state before this cycle). collisionLive <= this cycle's overlap bits only (cleared, then the new-frame pixel is applied).

## Timing
- Pixel path latency is 1 cycle. Outputs at edge N+1 reflect inputs sampled at edge N.
- Winner selection uses the active table as it stood before edge N. A startOfFrame at edge N affects pixels from N+1 onward.
- A prioWrEn without startOfFrame never changes the output within the current frame.
- collisionPulse has the same 1-cycle latency as the pixel path. collisionLive/collisionFrame update on the same edge.
- Reset (async, any time, including mid-frame):
  - drawingRequest=0, rgbOut=BG_RGB, topCh=0, collisionPulse=0, collisionLive=0, collisionFrame=0.
  - Both tables return to identity order.
  - After release, the first edge behaves as normal operation; no extra startOfFrame is required.
- All state and outputs are flops. No combinational path from inputs to outputs.

## Test plan
- Reset identity order, NUM_CH=8: chRequest=8'b0000_0110, chRGB[1]=8'h1C, chRGB[2]=8'hE0, all enabled -> next cycle drawingRequest=1, rgbOut=8'h1C, topCh=1, collisionPulse=1, collisionLive=8'b0000_0110.
- No requests -> rgbOut=8'hFF, drawingRequest=0, topCh=0. chEnable[1]=0 with the first stimulus -> rgbOut=8'hE0, topCh=2, collisionPulse=0.
- Write slot0<-ch2 mid-frame with requests 1 and 2 held -> topCh stays 1 until the cycle after startOfFrame, then topCh=2, rgbOut=8'hE0. Repeat with write and startOfFrame in the same cycle -> topCh=2 one cycle later.
- Collision across frames: overlap of ch3/ch5 in frame A, none in frame B -> at startOfFrame B, collisionFrame=8'b0010_1000, collisionLive=0. At start of C, collisionFrame=0.
- Overlap on the startOfFrame cycle itself (ch0+ch7) -> collisionLive=8'b1000_0001, and collisionFrame holds the prior frame's value.
- Assert reset mid-frame with a nonidentity table and collisionLive≠0 -> all outputs immediately at reset values. After release, ch0 beats ch1.
